supreme_meme: RTL and testbench

- Tiny Tapeout user block: a 7-segment message scroller.
- It cycles the message "SUPrEME" plus one blank digit on the dedicated outputs, at a rate selected by ui_in.
- It exposes its internal state on the bidirectional pins, which are always driven as outputs.
- It sits directly under the Tiny Tapeout top-level wrapper and uses the standard user-project pinout.

---
 rtl/supreme_meme.sv | 82 ++++++++
 tb/tb_supreme_meme.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/supreme_meme.sv
// Tiny Tapeout 7-segment scroller for "SUPrEME" with a heartbeat and status bus.
// Optional Galois LFSR display mode is enabled by defining SUPREME_MEME_LFSR_EN.
module supreme_meme (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [19:0] r_cnt;
    logic [2:0]  r_idx;
    logic        r_hb;
    logic [4:0]  w_shift;
    logic [19:0] w_mask;
    logic        w_tick;
    logic [6:0]  w_rom;
    logic        w_unused;

    // Tick when the low (speed+4) bits of the prescaler are all ones.
    assign w_shift = {1'b0, ui_in[7:4]} + 5'd4;
    assign w_mask  = (20'd1 << w_shift) - 20'd1;
    assign w_tick  = ena & ui_in[0] & ((r_cnt & w_mask) == w_mask);

    assign uio_oe   = 8'hFF;
    assign w_unused = &{1'b0, uio_in, ui_in[3], ui_in[2]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
            r_hb  <= 1'b0;
        end else if (ena) begin
            r_cnt <= r_cnt + 20'd1;
            if (w_tick) begin
                r_idx <= ui_in[1] ? (r_idx - 3'd1) : (r_idx + 3'd1);
                r_hb  <= ~r_hb;
            end
        end
    end

`ifdef SUPREME_MEME_LFSR_EN
    logic [7:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lfsr <= 8'h01;
        end else if (w_tick) begin
            r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? 8'hB8 : 8'h00);
        end
    end
`endif

    always_comb begin
        w_rom = 7'h00;
        case (r_idx)
            3'd0: w_rom = 7'h6D;
            3'd1: w_rom = 7'h3E;
            3'd2: w_rom = 7'h73;
            3'd3: w_rom = 7'h50;
            3'd4: w_rom = 7'h79;
            3'd5: w_rom = 7'h37;
            3'd6: w_rom = 7'h79;
            default: w_rom = 7'h00;
        endcase
    end

    always_comb begin
        uo_out  = {r_hb, w_rom};
        uio_out = {5'b0, r_idx};
`ifdef SUPREME_MEME_LFSR_EN
        if (ui_in[2]) begin
            uo_out  = {r_hb, r_lfsr[6:0]};
            uio_out = r_lfsr;
        end
`endif
    end

endmodule

// File: tb/tb_supreme_meme.sv
// Directed bench for supreme_meme: reset, scroll up/down, holds, speed change, LFSR mode.
// Expected values follow the SUPREME_MEME_LFSR_EN setting of the build.
module tb_supreme_meme;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int unsigned n_checks;
    int unsigned n_pass;

    supreme_meme u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [7:0] seq_up [8];
    logic [7:0] lf_uio [4];
    logic [7:0] lf_uo  [4];

    initial begin
        n_checks = 0;
        n_pass   = 0;
        // Expected uo_out after each of 8 up-ticks from idx 0 (heartbeat folded in).
        seq_up = '{8'hBE, 8'h73, 8'hD0, 8'h79, 8'hB7, 8'h79, 8'h80, 8'h6D};
`ifdef SUPREME_MEME_LFSR_EN
        lf_uio = '{8'h01, 8'hB8, 8'h5C, 8'h2E};
        lf_uo  = '{8'h01, 8'hB8, 8'h5C, 8'hAE};
`else
        lf_uio = '{8'h00, 8'h01, 8'h02, 8'h03};
        lf_uo  = '{8'h6D, 8'hBE, 8'h73, 8'hD0};
`endif

        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'hA5;
        step(2);
        chk("rst_uo", uo_out, 8'h6D);
        chk("rst_uio", uio_out, 8'h00);
        chk("rst_oe", uio_oe, 8'hFF);

        // Scroll up at speed 0; reserved bit 3 and uio_in set to show they are ignored.
        rst_n = 1'b1;
        ui_in = 8'h09;
        step(15);
        chk("up_pre_tick", uo_out, 8'h6D);
        step(1);
        chk("up_tick1", uo_out, seq_up[0]);
        chk("up_idx1", uio_out, 8'h01);
        for (int i = 1; i < 8; i++) begin
            step(16);
            chk($sformatf("up_tick%0d", i + 1), uo_out, seq_up[i]);
        end
        chk("up_wrap_idx", uio_out, 8'h00);

        // Scroll down from idx 0 (cnt = 128).
        ui_in = 8'h03;
        step(16);
        chk("dn_tick1", uo_out, 8'h80);
        chk("dn_idx7", uio_out, 8'h07);
        step(16);
        chk("dn_tick2", uo_out, 8'h79);
        chk("dn_idx6", uio_out, 8'h06);

        // run=0 for 100 cycles: display holds, cnt advances to 260.
        ui_in = 8'h00;
        step(100);
        chk("hold_uo", uo_out, 8'h79);
        chk("hold_uio", uio_out, 8'h06);
        ui_in = 8'h01;
        step(11);
        chk("resume_pre", uo_out, 8'h79);
        step(1);
        chk("resume_tick", uo_out, 8'h80);

        // ena=0 freezes cnt at 272; next tick still 16 enabled edges away.
        ena = 1'b0;
        step(37);
        chk("ena0_hold", uo_out, 8'h80);
        ena = 1'b1;
        step(15);
        chk("ena1_pre", uo_out, 8'h80);
        step(1);
        chk("ena1_tick", uo_out, 8'h6D);

        // Speed 1 from cnt = 288: tick after 32 edges.
        ui_in = 8'h11;
        step(31);
        chk("spd1_pre", uo_out, 8'h6D);
        step(1);
        chk("spd1_tick", uo_out, 8'hBE);
        // At cnt = 328 drop to speed 0: tick at cnt[3:0]=15 (cnt 335), not 351.
        step(8);
        ui_in = 8'h01;
        step(7);
        chk("spd0_pre", uo_out, 8'hBE);
        step(1);
        chk("spd0_tick", uo_out, 8'h73);

        // Reset mid-scroll with run and ena active.
        rst_n = 1'b0;
        step(1);
        chk("midrst_uo", uo_out, 8'h6D);
        chk("midrst_uio", uio_out, 8'h00);

        // Mode 1 (LFSR when built in) from reset.
        rst_n = 1'b1;
        ui_in = 8'h05;
        #0;
        chk("lf_uio0", uio_out, lf_uio[0]);
        chk("lf_uo0", uo_out, lf_uo[0]);
        for (int i = 1; i < 4; i++) begin
            step(16);
            chk($sformatf("lf_uio%0d", i), uio_out, lf_uio[i]);
            chk($sformatf("lf_uo%0d", i), uo_out, lf_uo[i]);
        end
        // Back to message mode: idx advanced on every tick regardless of mode.
        ui_in = 8'h01;
        #1;
        chk("mode0_idx", uio_out, 8'h03);
        chk("mode0_uo", uo_out, 8'hD0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
